fir_sample_feeder: RTL and testbench

Transmit-side feeder for the folded FIR datapath. Accepts samples from an upstream valid/ready stream and buffers them in a small FIFO. Emits exactly one sample per frame of N_TAPS clk cycles on dout, with a one-cycle frame_strobe, and drives the FIR input register at the frame rate. Decouples bursty producers from the fixed-rate MAC schedule.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_feeder_fifo.sv | 56 +++++
 rtl/fir_sample_feeder.sv | 101 ++++++++++
 tb/tb_fir_sample_feeder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR datapath: feeder FSM encoding and
// default widths used by both the feeder and the FIR top.
package fir_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } feeder_state_t;

  localparam int DEFAULT_WIDTH_DATA = 8;
  localparam int DEFAULT_N_TAPS     = 16;

endpackage

// File: rtl/fir_feeder_fifo.sv
// Single-clock sample FIFO for the FIR feeder. Pointers carry one extra wrap
// bit so full/empty come from a plain compare; read data is the head entry.
module fir_feeder_fifo
  import fir_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH_DATA,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Fixed-rate sample feeder: buffers a bursty stream and presents one sample per
// N_TAPS-cycle frame. Define FIR_FEEDER_HOLD_LAST_EN to hold dout on underrun.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA  = DEFAULT_WIDTH_DATA,
  parameter int N_TAPS      = DEFAULT_N_TAPS,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH_DATA-1:0]       s_data,
  input  logic                        flush,
  output logic [WIDTH_DATA-1:0]       dout,
  output logic                        frame_strobe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  localparam int              CW        = $clog2(N_TAPS);
  localparam int              LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   LAST      = CW'(N_TAPS - 1);
  localparam logic [LW-1:0]   PRIME_LVL = LW'(PRIME_LEVEL);

  feeder_state_t         state;
  feeder_state_t         state_next;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  boundary;
  logic [WIDTH_DATA-1:0] head;
  logic [WIDTH_DATA-1:0] fill;

  // s_ready depends only on stored pointers, never on this cycle's pop.
  assign s_ready  = !full;
  assign push     = s_valid && !full;
  assign boundary = (state == RUN) && (cnt == LAST);
  assign pop      = boundary && !empty;

`ifdef FIR_FEEDER_HOLD_LAST_EN
  assign fill = dout;
`else
  assign fill = '0;
`endif

  fir_feeder_fifo #(
    .WIDTH (WIDTH_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (s_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= PRIME;
    else if (flush) state <= PRIME;
    else            state <= state_next;
  end

  // NOTE: state_next gets its default before any condition so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (state == PRIME && fifo_level >= PRIME_LVL) state_next = RUN;
  end

  // N_TAPS is a power of two, so the counter wraps on its own overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         cnt <= '0;
    else if (flush || state == PRIME) cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout         <= '0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else if (flush) begin
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= boundary;
      if (boundary) dout <= empty ? fill : head;
      if (boundary && empty) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: queue-based frame model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fir_sample_feeder;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int D  = 8;
  localparam int PL = 4;

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         s_valid = 1'b0;
  logic         flush   = 1'b0;
  logic [W-1:0] s_data  = '0;
  logic         s_ready;
  logic [W-1:0] dout;
  logic         frame_strobe;
  logic [3:0]   fifo_level;
  logic         underrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;
  int n;

  fir_sample_feeder #(
    .WIDTH_DATA  (W),
    .N_TAPS      (N),
    .FIFO_DEPTH  (D),
    .PRIME_LEVEL (PL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .flush        (flush),
    .dout         (dout),
    .frame_strobe (frame_strobe),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a sample queue, a running flag and a cycle-in-frame index.
  logic [W-1:0] mq[$];
  bit           m_run    = 1'b0;
  int           m_cnt    = 0;
  logic [W-1:0] m_dout   = '0;
  bit           m_strobe = 1'b0;
  bit           m_under  = 1'b0;
  bit           m_accept;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_run = 1'b0; m_cnt = 0; m_dout = '0; m_strobe = 1'b0; m_under = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_run = 1'b0; m_cnt = 0; m_strobe = 1'b0;
    end else begin
      m_accept = s_valid && (mq.size() < D);
      m_strobe = m_run && (m_cnt == N - 1);
      if (m_strobe) begin
        if (mq.size() != 0) m_dout = mq.pop_front();
        else begin
`ifndef FIR_FEEDER_HOLD_LAST_EN
          m_dout = '0;
`endif
          m_under = 1'b1;
        end
      end
      if (m_run) m_cnt = (m_cnt + 1) % N;
      else if (mq.size() >= PL) m_run = 1'b1;
      if (m_accept) mq.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_dout", 32'(dout), 32'(m_dout));
      check("model_strobe", 32'(frame_strobe), 32'(m_strobe));
      check("model_level", 32'(fifo_level), 32'(mq.size()));
      check("model_s_ready", 32'(s_ready), 32'(mq.size() < D));
      check("model_underrun", 32'(underrun), 32'(m_under));
    end
  end

  // Returns the number of edges until a strobe is seen, or 0 on timeout.
  task automatic wait_strobe(input int max, output int cycles);
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (frame_strobe) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) tick();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_underrun", 32'(underrun), 32'd0);
    check_en = 1'b1;
    rst = 1'b1;
    tick();

    // Prime with 4..7, then four frames drain them.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(4 + i); tick();
    end
    s_valid = 1'b0;
    check("prime_level", 32'(fifo_level), 32'd4);
    wait_strobe(40, n);
    check("first_strobe_latency", 32'(n), 32'd17);
    check("frame1_dout", 32'(dout), 32'd4);
    check("frame1_level", 32'(fifo_level), 32'd3);
    for (int k = 1; k < 4; k++) begin
      wait_strobe(40, n);
      check("frame_period", 32'(n), 32'd16);
      check("frame_dout", 32'(dout), 32'(4 + k));
      check("frame_level", 32'(fifo_level), 32'(3 - k));
    end
    check("no_underrun_yet", 32'(underrun), 32'd0);
    wait_strobe(40, n);
    check("underrun_period", 32'(n), 32'd16);
`ifdef FIR_FEEDER_HOLD_LAST_EN
    check("underrun_dout", 32'(dout), 32'd7);
`else
    check("underrun_dout", 32'(dout), 32'd0);
`endif
    check("underrun_flag", 32'(underrun), 32'd1);

    // Backpressure: 10 offered, 8 accepted; first strobe reopens one slot.
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'(10 + i); tick();
      if (i == 7) check("full_s_ready", 32'(s_ready), 32'd0);
    end
    check("full_level", 32'(fifo_level), 32'd8);
    s_data = 8'd99;
    wait_strobe(40, n);
    check("bp_strobe_latency", 32'(n), 32'd11);
    check("bp_dout", 32'(dout), 32'd10);
    check("bp_level", 32'(fifo_level), 32'd7);
    check("bp_reopen", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    check("bp_refill_level", 32'(fifo_level), 32'd8);
    check("bp_refill_ready", 32'(s_ready), 32'd0);

    // Drain to level 3, then push exactly on the boundary edge.
    for (int k = 0; k < 5; k++) begin
      wait_strobe(40, n);
      check("drain_dout", 32'(dout), 32'(11 + k));
    end
    check("drain_level", 32'(fifo_level), 32'd3);
    repeat (15) tick();
    s_valid = 1'b1; s_data = 8'h55; tick(); s_valid = 1'b0;
    check("pushpop_strobe", 32'(frame_strobe), 32'd1);
    check("pushpop_level", 32'(fifo_level), 32'd3);
    check("pushpop_dout", 32'(dout), 32'd16);

    // Level 5, flush at counter 9 with a push offered in the flush cycle.
    s_valid = 1'b1; s_data = 8'h66; tick();
    s_data = 8'h77; tick(); s_valid = 1'b0;
    check("preflush_level", 32'(fifo_level), 32'd5);
    repeat (7) tick();
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; tick();
    flush = 1'b0; s_valid = 1'b0;
    check("midflush_level", 32'(fifo_level), 32'd0);
    check("midflush_strobe", 32'(frame_strobe), 32'd0);
    check("midflush_dout", 32'(dout), 32'd16);
    check("midflush_underrun", 32'(underrun), 32'd1);
    wait_strobe(40, n);
    check("no_strobe_in_prime", 32'(n), 32'd0);

    // Re-prime, then async reset while the strobe is high.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h21 + i); tick();
    end
    s_valid = 1'b0;
    wait_strobe(40, n);
    check("reprime_latency", 32'(n), 32'd17);
    check("reprime_dout", 32'(dout), 32'h21);
    #2 rst = 1'b0;
    #1;
    check("async_dout", 32'(dout), 32'd0);
    check("async_strobe", 32'(frame_strobe), 32'd0);
    check("async_level", 32'(fifo_level), 32'd0);
    check("async_s_ready", 32'(s_ready), 32'd1);
    check("async_underrun", 32'(underrun), 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
